// File: rtl/div.sv
// rtl/div.sv - 32-bit signed/unsigned radix-2 restoring divider with start/ready handshake

module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [5:0]  cnt;
    logic [31:0] rem;        // partial remainder
    logic [31:0] quot;       // dividend bits shift out, quotient bits shift in
    logic [31:0] divisor;    // divisor magnitude
    logic        neg_quot;   // dividend and divisor signs differed
    logic        neg_rem;    // dividend was negative

    logic        accept;
    logic [31:0] mag1;
    logic [31:0] mag2;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    assign accept = start_i && !annul_i;

    // Operand magnitudes; unsigned mode passes the raw values through
    assign mag1 = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    assign mag2 = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

    // One restoring step: bring the next dividend bit into the remainder and trial-subtract.
    // The 33-bit width keeps the borrow in bit 32 even when the shifted remainder exceeds 2^32.
    assign shifted = {rem, quot[31]};
    assign diff    = shifted - {1'b0, divisor};

    // Final sign correction; quotient truncates toward zero, remainder follows the dividend
    assign quot_fix = neg_quot ? (~quot + 32'd1) : quot;
    assign rem_fix  = neg_rem  ? (~rem + 32'd1)  : rem;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FREE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; only annul_i aborts a running operation, start_i dropping does not
    always_comb begin
        state_nxt = state;
        case (state)
            FREE: begin
                if (accept) begin
                    state_nxt = (opdata2_i == 32'd0) ? BYZERO : ON;
                end
            end
            BYZERO: begin
                state_nxt = annul_i ? FREE : END;
            end
            ON: begin
                if (annul_i) begin
                    state_nxt = FREE;
                end else if (cnt == 6'd32) begin
                    state_nxt = END;
                end
            end
            END: begin
                // Leave only once the result has been presented and the requester let go
                if (ready_o && !start_i) begin
                    state_nxt = FREE;
                end
            end
            default: state_nxt = FREE;
        endcase
    end

    // Datapath: operand capture, iteration, fixup and result/ready registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= 6'd0;
            rem      <= 32'd0;
            quot     <= 32'd0;
            divisor  <= 32'd0;
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
            ready_o  <= 1'b0;
            result_o <= 64'h0;
        end else begin
            case (state)
                FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= 64'h0;
                    if (accept) begin
                        cnt      <= 6'd0;
                        rem      <= 32'd0;
                        quot     <= mag1;
                        divisor  <= mag2;
                        neg_quot <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
                        neg_rem  <= signed_div_i && opdata1_i[31];
                    end
                end
                BYZERO: begin
                    ready_o  <= 1'b0;
                    result_o <= 64'h0;
                end
                ON: begin
                    if (annul_i) begin
                        ready_o  <= 1'b0;
                        result_o <= 64'h0;
                    end else if (cnt == 6'd32) begin
                        result_o <= {rem_fix, quot_fix};
                        ready_o  <= 1'b1;
                    end else begin
                        if (diff[32]) begin
                            rem  <= shifted[31:0];
                            quot <= {quot[30:0], 1'b0};
                        end else begin
                            rem  <= diff[31:0];
                            quot <= {quot[30:0], 1'b1};
                        end
                        cnt <= cnt + 6'd1;
                    end
                end
                END: begin
                    if (!ready_o) begin
                        // Divide-by-zero arrives here with ready still low; result is already zero
                        ready_o <= 1'b1;
                    end else if (!start_i) begin
                        ready_o  <= 1'b0;
                        result_o <= 64'h0;
                    end
                end
                default: begin
                    ready_o  <= 1'b0;
                    result_o <= 64'h0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
// tb/tb_div.sv - self-checking bench for div against an arithmetic reference model

module tb_div;

    logic        clk;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int compared;
    int mismatched;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {remainder, quotient} from plain 64-bit arithmetic, zero for a zero divisor
    function automatic logic [63:0] model(input logic sg, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] qv, rv;
        if (b == 32'd0) return 64'h0;
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q  = sa / sb;
        r  = sa % sb;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Count edges from the accepting edge until ready, then check latency and result
    task automatic await_result(input string tag, input int lat, input logic [63:0] exp);
        int n;
        n = 0;
        while (!ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(lat));
        chk({tag, "_result"}, result, exp);
    endtask

    task automatic release_start(input string tag);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_rel_ready"}, {63'd0, ready}, 64'd0);
        chk({tag, "_rel_result"}, result, 64'h0);
    endtask

    task automatic run_op(input string tag, input logic sg, input logic [31:0] a,
                          input logic [31:0] b, input int hold_extra);
        logic [63:0] exp;
        int          lat;
        exp = model(sg, a, b);
        lat = (b == 32'd0) ? 2 : 33;
        @(negedge clk);
        signed_div = sg;
        op1        = a;
        op2        = b;
        start      = 1'b1;
        @(posedge clk);
        #1;
        // Operands change after acceptance and must not matter
        op1        = $urandom;
        op2        = $urandom;
        signed_div = 1'($urandom);
        await_result(tag, lat, exp);
        for (int i = 0; i < hold_extra; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "_hold_result"}, result, exp);
            chk({tag, "_hold_ready"}, {63'd0, ready}, 64'd1);
        end
        release_start(tag);
    endtask

    initial begin
        logic [31:0] a, b;
        logic        sg;
        int          seen;
        compared   = 0;
        mismatched = 0;
        rst        = 1'b0;
        signed_div = 1'b0;
        op1        = 32'd0;
        op2        = 32'd0;
        start      = 1'b0;
        annul      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", {63'd0, ready}, 64'd0);
        chk("reset_result", result, 64'h0);
        @(negedge clk);
        rst = 1'b1;

        run_op("u100_7", 1'b0, 32'd100, 32'd7, 0);
        chk("u100_7_const", model(1'b0, 32'd100, 32'd7), 64'h00000002_0000000E);
        run_op("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'h2, 0);
        run_op("u_ff_1", 1'b0, 32'hFFFFFFFF, 32'h1, 0);
        run_op("byzero", 1'b1, 32'd1234, 32'd0, 0);
        run_op("overflow", 1'b1, 32'h80000000, 32'hFFFFFFFF, 5);
        run_op("s_pos_neg", 1'b1, 32'd17, 32'hFFFFFFFB, 0);
        run_op("u_small_big", 1'b0, 32'd5, 32'hFFFFFFF0, 0);

        // Annul at cycle 10 of ON: back to FREE, ready never shows
        @(negedge clk);
        signed_div = 1'b0;
        op1        = 32'd1000;
        op2        = 32'd3;
        start      = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        start = 1'b0;
        seen  = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready) seen++;
        end
        chk("annul_no_ready", 64'(seen), 64'd0);
        run_op("after_annul_9_3", 1'b0, 32'd9, 32'd3, 0);

        // Asynchronous reset at cycle 20 of ON, then a full-latency rerun with start still high
        @(negedge clk);
        signed_div = 1'b1;
        op1        = 32'hFFFF0000;
        op2        = 32'd77;
        start      = 1'b1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("rst_mid_ready", {63'd0, ready}, 64'd0);
        chk("rst_mid_result", result, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        await_result("rst_rerun", 33, model(1'b1, 32'hFFFF0000, 32'd77));

        // Asynchronous reset while a result is presented clears it without an edge
        #2;
        rst = 1'b0;
        #1;
        chk("rst_end_ready", {63'd0, ready}, 64'd0);
        chk("rst_end_result", result, 64'h0);
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b1;
        seen  = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready) seen++;
        end
        chk("rst_no_ready", 64'(seen), 64'd0);

        // Randomized operations against the model
        for (int i = 0; i < 24; i++) begin
            sg = 1'($urandom);
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFFFFFF;
                3: a = 32'h80000000;
                default: ;
            endcase
            run_op($sformatf("rand%0d", i), sg, a, b, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-low reset; 0 = reset asserted.
REQ-004 signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
REQ-005 opdata1_i  input  32  dividend; sampled at start acceptance.
REQ-006 opdata2_i  input  32  divisor; sampled at start acceptance.
REQ-007 start_i  input  1  request from EX stage, held high until ready_o is seen.
REQ-008 annul_i  input  1  cancel current operation (pipeline flush).
REQ-009 result_o  output  64  {remainder, quotient}; [63:32] goes to HI, [31:0] goes to LO.
REQ-010 ready_o  output  1  result_o valid.

Function
REQ-011 States SHALL be FREE, BYZERO, ON and END, with a 6-bit iteration counter cnt.
REQ-012 FREE transitions:
- start_i=1, annul_i=0, opdata2_i=0: go to BYZERO.
- start_i=1, annul_i=0, opdata2_i≠0: go to ON, cnt=0, operands captured.
- Otherwise stay in FREE, with ready_o=0 and result_o=0.
REQ-013 Signed-mode operand capture:
- Negative operands SHALL be converted to magnitude (two's complement).
- Operand signs SHALL be latched for the final fixup.
- Unsigned mode uses the raw values.
REQ-014 ON performs radix-2 restoring division, one quotient bit per cycle, for 32 cycles (cnt 0→32).
- Each cycle: partial remainder shifted left one bit; the divisor is subtracted from it.
- The subtraction is 33-bit, so a borrow is detected without overflow.
- Borrow: quotient bit = 0 and the partial remainder is kept.
- No borrow: quotient bit = 1 and the partial remainder is replaced by the difference.
REQ-015 ON with cnt=32 (the 33rd cycle after acceptance):
- Signed fixup is applied.
- The result is registered into result_o, ready_o is set to 1, and the state goes to END.
REQ-016 Signed fixup rules:
- Quotient is negated if the dividend and divisor signs differ.
- Remainder is negated if the dividend is negative.
- Quotient truncates toward zero.
REQ-017 0x80000000 / 0xFFFFFFFF signed SHALL yield quotient 0x80000000, remainder 0; no exception or flag.
REQ-018 BYZERO SHALL go to END on the next edge with result_o=64'h0 and ready_o=1.
REQ-019 END SHALL hold result_o and ready_o stable while start_i=1.
- When start_i=0, the next edge goes to FREE with ready_o=0 and result_o=0.
REQ-020 annul_i=1 in ON or BYZERO SHALL return the block to FREE on the next edge, with ready_o remaining 0.
REQ-021 Deasserting start_i during ON or BYZERO SHALL NOT abort the operation; only annul_i aborts.
REQ-022 Operand input changes after acceptance SHALL NOT affect the result.
REQ-023 Latency: ready_o SHALL be 1 exactly 33 clocks after the accepting edge (2 clocks for divide-by-zero).
- Total occupancy is 34 cycles including the END handshake cycle.
REQ-024 A new start SHALL be accepted only in FREE; back-to-back operations therefore have at least one FREE cycle between them.

Reset
REQ-025 When rst is low, immediately and asynchronously:
- state = FREE, cnt = 0, ready_o = 0, result_o = 64'h0;
- internal remainder, quotient, and latched-sign registers = 0.
REQ-026 Reset asserted mid-operation SHALL discard the operation.
- After rst deasserts, no ready_o is produced until a new start is accepted.

Verification
REQ-027 Unsigned 100/7: start with opdata1=32'd100, opdata2=32'd7 -> ready_o=1 at accept+33, result_o=64'h00000002_0000000E.
REQ-028 Signed -7/2: opdata1=0xFFFFFFF9, opdata2=0x2 -> result_o=64'hFFFFFFFF_FFFFFFFD; unsigned 0xFFFFFFFF/1 -> 64'h00000000_FFFFFFFF.
REQ-029 Divide by zero: opdata2=0 -> ready_o=1 at accept+2, result_o=0; start_i dropped -> FREE next edge with ready_o=0.
REQ-030 Annul at cycle 10 of ON -> FREE next edge, ready_o never asserts; a following start 9/3 -> result_o=64'h00000000_00000003.
REQ-031 rst driven low at cycle 20 of ON, asynchronous to clk -> ready_o=0 and result_o=0 without waiting for an edge; after release with start_i still high and the same operands, the full 33-cycle latency applies.
REQ-032 Overflow: signed 0x80000000/0xFFFFFFFF -> result_o=64'h00000000_80000000; hold start_i high 5 extra cycles -> result stable.
